// File: rtl/forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit
//
// This block is the pipeline-control logic for EX-stage operand forwarding and
// load-use stall detection.
//
// A small registered scoreboard tracks the destination of every instruction
// that sits in EX or MEM. The scoreboard advances in lock-step with the
// datapath pipeline registers. The operand-forwarding selects are resolved
// while the consumer is still in ID and are then registered, so they are
// glitch-free for the whole time the consumer spends in EX.
//
// The WB-stage instruction is not kept in the scoreboard. Two facts make it
// unnecessary:
//   - The register file is write-first, so an ID read of a register that WB is
//     writing in the same cycle already returns the new value.
//   - A MEM-entry match is reported as "WB result" (01), because that producer
//     is in WB by the time the consumer reaches EX.
// Nothing downstream therefore ever compares against the WB occupant.
//
// Select encoding (matches the EX operand mux inputs):
//   2'b00  register-file value
//   2'b01  WB result
//   2'b10  MEM-stage ALU result
//   2'b11  reserved, never produced
//
// Ports
//   i_clk            pipeline clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_pipe_en        1 = pipeline advances, 0 = every stage holds
//   i_id_valid       ID holds a real instruction
//   i_id_rs/rt       ID source register addresses
//   i_id_uses_rs/rt  ID instruction actually reads rs / rt
//   i_id_dest        ID destination register
//   i_id_reg_write   ID instruction writes the register file
//   i_id_mem_to_reg  ID instruction is a load
//   i_id_flush       taken branch/jump squashes the ID instruction
//   o_fwd_a_sel      registered select for EX operand A
//   o_fwd_b_sel      registered select for EX operand B
//   o_stall          load-use stall request (hold PC, IF/ID; bubble ID/EX)
// -----------------------------------------------------------------------------
module forward_hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pipe_en,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic [REG_ADDR_W-1:0] i_id_dest,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_to_reg,
  input  logic                  i_id_flush,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_stall
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  // EX entry: needs mem_to_reg, because a load in EX cannot forward yet.
  logic                  r_ex_valid;
  logic [REG_ADDR_W-1:0] r_ex_dest;
  logic                  r_ex_reg_write;
  logic                  r_ex_mem_to_reg;

  // MEM entry: by the time the consumer reaches EX, this producer is in WB.
  // Load data is available there as well, so the load flag is not tracked.
  logic                  r_mem_valid;
  logic [REG_ADDR_W-1:0] r_mem_dest;
  logic                  r_mem_reg_write;

  // Registered selects, one per operand (index 0 = A/rs, 1 = B/rt).
  logic [1:0][1:0]       r_sel;

  // ---------------------------------------------------------------------------
  // Per-operand forwarding decode
  // ---------------------------------------------------------------------------
  logic [1:0][REG_ADDR_W-1:0] w_src;
  logic [1:0]                 w_use;
  logic [1:0]                 w_ex_hit;
  logic [1:0]                 w_mem_hit;
  logic [1:0]                 w_load_hit;
  logic [1:0][1:0]            w_next_sel;

  assign w_src[0] = i_id_rs;
  assign w_src[1] = i_id_rt;
  assign w_use[0] = i_id_uses_rs;
  assign w_use[1] = i_id_uses_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // Producer match: a live writer of a nonzero register equal to the
      // source. Register $0 is hard-wired, so it never matches.
      assign w_ex_hit[gi]  = r_ex_valid  & r_ex_reg_write  &
                             (r_ex_dest  != '0) & (r_ex_dest  == w_src[gi]);
      assign w_mem_hit[gi] = r_mem_valid & r_mem_reg_write &
                             (r_mem_dest != '0) & (r_mem_dest == w_src[gi]);

      // A load in EX has no data until it reaches WB, so this operand forces a
      // one-cycle bubble.
      assign w_load_hit[gi] = i_id_valid & w_use[gi] & w_ex_hit[gi] & r_ex_mem_to_reg;

      // Newest producer wins: the EX entry (becomes MEM) beats the MEM entry
      // (becomes WB). An EX-load match falls through. It only matters when no
      // bubble is inserted, and a load-use always inserts one.
      always_comb begin
        w_next_sel[gi] = SEL_RF;
        if (i_id_valid && w_use[gi]) begin
          if (w_ex_hit[gi] && !r_ex_mem_to_reg) begin
            w_next_sel[gi] = SEL_MEM;
          end else if (w_mem_hit[gi]) begin
            w_next_sel[gi] = SEL_WB;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stall / bubble
  // ---------------------------------------------------------------------------
  logic w_load_use;
  logic w_bubble;

  assign w_load_use = |w_load_hit;
  // A squashed instruction does not wait for its operands. The flush alone
  // turns the ID/EX slot into a bubble.
  assign o_stall    = w_load_use & ~i_id_flush;
  assign w_bubble   = w_load_use | i_id_flush;

  // ---------------------------------------------------------------------------
  // Scoreboard and select registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_dest       <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_mem_dest      <= '0;
      r_mem_reg_write <= 1'b0;
      r_sel           <= '0;
    end else if (i_pipe_en) begin
      r_mem_valid     <= r_ex_valid;
      r_mem_dest      <= r_ex_dest;
      r_mem_reg_write <= r_ex_reg_write;

      if (w_bubble) begin
        r_ex_valid      <= 1'b0;
        r_ex_dest       <= '0;
        r_ex_reg_write  <= 1'b0;
        r_ex_mem_to_reg <= 1'b0;
        r_sel           <= '0;
      end else begin
        r_ex_valid      <= i_id_valid;
        r_ex_dest       <= i_id_dest;
        r_ex_reg_write  <= i_id_reg_write;
        r_ex_mem_to_reg <= i_id_mem_to_reg;
        r_sel           <= w_next_sel;
      end
    end
  end

  assign o_fwd_a_sel = r_sel[0];
  assign o_fwd_b_sel = r_sel[1];

endmodule

// File: tb/tb_forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_forward_hazard_unit
//
// Table of directed instruction sequences with constant expectations, a
// hand-written asynchronous-reset sequence, and a randomized run checked
// against a stage-list reference model.
// -----------------------------------------------------------------------------
module tb_forward_hazard_unit;

  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic         pipe_en;
  logic         id_valid;
  logic [W-1:0] id_rs;
  logic [W-1:0] id_rt;
  logic         id_uses_rs;
  logic         id_uses_rt;
  logic [W-1:0] id_dest;
  logic         id_reg_write;
  logic         id_mem_to_reg;
  logic         id_flush;
  logic [1:0]   fwd_a_sel;
  logic [1:0]   fwd_b_sel;
  logic         stall;

  forward_hazard_unit #(.REG_ADDR_W(W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pipe_en      (pipe_en),
    .i_id_valid     (id_valid),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_uses_rs   (id_uses_rs),
    .i_id_uses_rt   (id_uses_rt),
    .i_id_dest      (id_dest),
    .i_id_reg_write (id_reg_write),
    .i_id_mem_to_reg(id_mem_to_reg),
    .i_id_flush     (id_flush),
    .o_fwd_a_sel    (fwd_a_sel),
    .o_fwd_b_sel    (fwd_b_sel),
    .o_stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       pe;
    logic       v;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic       urs;
    logic       urt;
    logic [W-1:0] dest;
    logic       rw;
    logic       ld;
    logic       fl;
    logic       exp_stall;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  vec_t tbl[$];
  vec_t post_rst[$];

  function automatic vec_t mk(input logic pe, v, input int rs, rt,
                              input logic urs, urt, input int dest,
                              input logic rw, ld, fl, st,
                              input logic [1:0] a, b);
    vec_t x;
    x.pe = pe; x.v = v; x.rs = W'(rs); x.rt = W'(rt);
    x.urs = urs; x.urt = urt; x.dest = W'(dest);
    x.rw = rw; x.ld = ld; x.fl = fl;
    x.exp_stall = st; x.exp_a = a; x.exp_b = b;
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rw;
    logic         ld;
  } ent_t;

  ent_t       m_stage [2];
  logic [1:0] m_a;
  logic [1:0] m_b;

  function automatic bit writes_reg(input ent_t e, input logic [W-1:0] r);
    return e.v && e.rw && (e.d != 0) && (e.d == r);
  endfunction

  // Value of the operand comes from the newest in-flight writer. Writer in EX
  // now is in MEM next (code 2) unless it is a load. Writer in MEM now is in
  // WB next (code 1).
  function automatic logic [1:0] model_sel(input logic [W-1:0] r, input logic u);
    if (!(id_valid && u)) return 2'd0;
    for (int s = 0; s < 2; s++) begin
      if (writes_reg(m_stage[s], r)) begin
        if (s == 0 && m_stage[0].ld) continue;
        return (s == 0) ? 2'd2 : 2'd1;
      end
    end
    return 2'd0;
  endfunction

  function automatic bit model_load_use();
    return id_valid && m_stage[0].ld &&
           ((id_uses_rs && writes_reg(m_stage[0], id_rs)) ||
            (id_uses_rt && writes_reg(m_stage[0], id_rt)));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) m_stage[s] = '{v: 1'b0, d: '0, rw: 1'b0, ld: 1'b0};
    m_a = 2'd0;
    m_b = 2'd0;
  endtask

  // Called right after a rising edge; the inputs still hold their pre-edge values.
  task automatic model_edge();
    bit         bubble;
    logic [1:0] na;
    logic [1:0] nb;
    if (!pipe_en) return;
    bubble = model_load_use() || id_flush;
    na = model_sel(id_rs, id_uses_rs);
    nb = model_sel(id_rt, id_uses_rt);
    m_stage[1] = m_stage[0];
    if (bubble) begin
      m_stage[0] = '{v: 1'b0, d: '0, rw: 1'b0, ld: 1'b0};
      m_a = 2'd0;
      m_b = 2'd0;
    end else begin
      m_stage[0] = '{v: id_valid, d: id_dest, rw: id_reg_write, ld: id_mem_to_reg};
      m_a = na;
      m_b = nb;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking / driving
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input int idx, input logic [1:0] act,
                     input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    pipe_en       = x.pe;
    id_valid      = x.v;
    id_rs         = x.rs;
    id_rt         = x.rt;
    id_uses_rs    = x.urs;
    id_uses_rt    = x.urt;
    id_dest       = x.dest;
    id_reg_write  = x.rw;
    id_mem_to_reg = x.ld;
    id_flush      = x.fl;
  endtask

  // One pipeline cycle, entered at a falling edge. The stall is checked before
  // the rising edge, and the selects are checked 1 ns after it.
  // use_tbl selects constant expectations instead of the model.
  task automatic apply(input vec_t x, input bit use_tbl, input int idx, input string tag);
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
    drive(x);
    #1;
    es = use_tbl ? x.exp_stall : logic'(model_load_use() && !id_flush);
    chk({tag, "_stall"}, idx, {1'b0, stall}, {1'b0, es});
    @(posedge clk);
    model_edge();
    #1;
    ea = use_tbl ? x.exp_a : m_a;
    eb = use_tbl ? x.exp_b : m_b;
    chk({tag, "_sel_a"}, idx, fwd_a_sel, ea);
    chk({tag, "_sel_b"}, idx, fwd_b_sel, eb);
    $display("%s #%0d pe=%0d v=%0d rs=%0d rt=%0d dest=%0d ld=%0d fl=%0d -> stall=%0d a=%0d b=%0d",
             tag, idx, x.pe, x.v, x.rs, x.rt, x.dest, x.ld, x.fl, stall, fwd_a_sel, fwd_b_sel);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic reset_pulse(input int idx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_stall", idx, {1'b0, stall}, 2'd0);
    chk("rst_sel_a", idx, fwd_a_sel, 2'd0);
    chk("rst_sel_b", idx, fwd_b_sel, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t nop_v;
  vec_t rv;

  initial begin
    // Sequences start from an empty pipeline.
    // add $3,$1,$2 ; sub $5,$3,$4 ; nop
    tbl.push_back(mk(1,1, 1,2, 1,1,  3, 1,0,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 3,4, 1,1,  5, 1,0,0, 0, 2'd2,2'd0));
    tbl.push_back(mk(1,0, 0,0, 0,0,  0, 0,0,0, 0, 2'd0,2'd0));
    // add $3 ; nop ; or $6,$2,$3
    tbl.push_back(mk(1,1, 1,2, 1,1,  3, 1,0,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,0, 0,0, 0,0,  0, 0,0,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 2,3, 1,1,  6, 1,0,0, 0, 2'd0,2'd1));
    // lw $8,0($1) ; add $9,$8,$8 (stall once, bubble, then WB forwarding)
    tbl.push_back(mk(1,1, 1,8, 1,0,  8, 1,1,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 8,8, 1,1,  9, 1,0,0, 1, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 8,8, 1,1,  9, 1,0,0, 0, 2'd1,2'd1));
    // add $2 ; sub $2 ; and $7,$2,$2 -> newest producer
    tbl.push_back(mk(1,1, 1,1, 1,1,  2, 1,0,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 1,1, 1,1,  2, 1,0,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 2,2, 1,1,  7, 1,0,0, 0, 2'd2,2'd2));
    // writes to $0 never forward, lw $0 never stalls
    tbl.push_back(mk(1,1, 1,1, 1,1,  0, 1,0,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 0,0, 1,1, 10, 1,0,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 0,0, 1,1, 11, 1,0,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 1,1, 1,0,  0, 1,1,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 0,0, 1,1, 12, 1,0,0, 0, 2'd0,2'd0));
    // lw $8 ; dependent with flush -> no stall, bubble (next $9 reader sees none)
    tbl.push_back(mk(1,1, 1,8, 1,0,  8, 1,1,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 8,8, 1,1,  9, 1,0,1, 0, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 9,9, 1,1,  3, 1,0,0, 0, 2'd0,2'd0));
    // sub $5,$3,$3 in EX, then 3-cycle hold, then or $6,$5,$3 (10 / 01)
    tbl.push_back(mk(1,1, 3,3, 1,1,  5, 1,0,0, 0, 2'd2,2'd2));
    tbl.push_back(mk(0,1, 5,3, 1,1,  6, 1,0,0, 0, 2'd2,2'd2));
    tbl.push_back(mk(0,1, 5,3, 1,1,  6, 1,0,0, 0, 2'd2,2'd2));
    tbl.push_back(mk(0,1, 5,3, 1,1,  6, 1,0,0, 0, 2'd2,2'd2));
    tbl.push_back(mk(1,1, 5,3, 1,1,  6, 1,0,0, 0, 2'd2,2'd1));
    // load-use under a hold: stall stays visible, then one bubble
    tbl.push_back(mk(1,1, 1,8, 1,0,  8, 1,1,0, 0, 2'd0,2'd0));
    tbl.push_back(mk(0,1, 8,8, 1,1,  9, 1,0,0, 1, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 8,8, 1,1,  9, 1,0,0, 1, 2'd0,2'd0));
    tbl.push_back(mk(1,1, 8,8, 1,1,  9, 1,0,0, 0, 2'd1,2'd1));

    // After a mid-stream reset: readers of $3 and $8 see no stale producers.
    post_rst.push_back(mk(1,1, 3,8, 1,1, 6, 1,0,0, 0, 2'd0,2'd0));
    post_rst.push_back(mk(1,1, 8,3, 1,1, 7, 1,0,0, 0, 2'd0,2'd0));
    post_rst.push_back(mk(1,1, 3,3, 1,1, 9, 1,0,0, 0, 2'd0,2'd0));

    nop_v = mk(1,0, 0,0, 0,0, 0, 0,0,0, 0, 2'd0,2'd0);

    // ---- power-on reset ----
    rst_n = 1'b0;
    drive(nop_v);
    model_reset();
    repeat (2) @(negedge clk);
    chk("por_stall", 0, {1'b0, stall}, 2'd0);
    chk("por_sel_a", 0, fwd_a_sel, 2'd0);
    chk("por_sel_b", 0, fwd_b_sel, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- directed table ----
    foreach (tbl[i]) apply(tbl[i], 1'b1, i, "tbl");

    // ---- reset mid-stream: add $3, lw $8 in flight, dependent in ID ----
    apply(mk(1,1, 1,1, 1,1, 3, 1,0,0, 0, 2'd0,2'd0), 1'b1, 0, "mrs");
    apply(mk(1,1, 1,8, 1,0, 8, 1,1,0, 0, 2'd0,2'd0), 1'b1, 1, "mrs");
    drive(mk(1,1, 8,8, 1,1, 9, 1,0,0, 0, 2'd0,2'd0));
    #1;
    chk("mrs_pre_stall", 2, {1'b0, stall}, 2'd1);
    reset_pulse(2);
    foreach (post_rst[i]) apply(post_rst[i], 1'b1, i, "post_rst");

    // ---- randomized run against the model ----
    for (int i = 0; i < 400; i++) begin
      rv.pe   = ($urandom_range(0, 4) != 0);
      rv.v    = ($urandom_range(0, 5) != 0);
      rv.rs   = W'($urandom_range(0, 3));
      rv.rt   = W'($urandom_range(0, 3));
      rv.urs  = $urandom_range(0, 1);
      rv.urt  = $urandom_range(0, 1);
      rv.dest = W'($urandom_range(0, 3));
      rv.rw   = ($urandom_range(0, 3) != 0);
      rv.ld   = ($urandom_range(0, 2) == 0);
      rv.fl   = ($urandom_range(0, 7) == 0);
      rv.exp_stall = 1'b0;
      rv.exp_a = 2'd0;
      rv.exp_b = 2'd0;
      apply(rv, 1'b0, i, "rnd");
      if (i % 150 == 149) reset_pulse(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
